// File: rtl/tron_mem_pkg.sv
// Shared types and constants for the Tron memory responder.
// Both the responder and its word RAM import this package.
package tron_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/tron_word_ram.sv
// Single-port word RAM: synchronous write, registered read, no reset.
// Contents power up to INIT_WORD and survive any reset of the surrounding logic.
module tron_word_ram
    import tron_mem_pkg::*;
#(
    parameter int               ADDR_BITS = 8,
    parameter logic [WORD_W-1:0] INIT_WORD = '0
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [WORD_W-1:0]    i_wdata,
    output logic [WORD_W-1:0]    o_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_W-1:0] r_mem [DEPTH] = '{default: INIT_WORD};
    logic [WORD_W-1:0] r_rdata = '0;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tron_mem_responder.sv
// Memory-side responder for the Tron core: accepts one fetch/LOAD/STORE at a time,
// inserts WAIT_STATES wait cycles, then pulses a one-cycle response.
module tron_mem_responder
    import tron_mem_pkg::*;
#(
    parameter int                ADDR_BITS   = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [WORD_W-1:0] INIT_WORD   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_write,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              busy
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_t             r_state;
    mem_state_t             w_state_next;
    logic [3:0]             r_wait_cnt;
    logic                   r_write;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WORD_W-1:0]      r_wdata;
    logic [WORD_W-1:0]      r_rsp_data;

    logic                   w_accept;
    logic                   w_preload;
    logic                   w_in_access;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [ADDR_BITS-1:0]   w_ram_addr;
    logic [WORD_W-1:0]      w_ram_wdata;
    logic [WORD_W-1:0]      w_ram_rdata;
    logic [WORD_W-1:0]      w_resp_word;
    logic                   w_unused_addr_bits;

    // Upper address bits are deliberately dropped: addresses wrap modulo DEPTH.
    assign w_unused_addr_bits = ^{req_addr[WORD_W-1:ADDR_BITS], load_addr[WORD_W-1:ADDR_BITS]};

    assign w_accept    = (r_state == IDLE) && req_valid && !reset;
    assign w_preload   = (r_state == IDLE) && load_en && !req_valid && !reset;
    assign w_in_access = (r_state == ACCESS);

    // The RAM port is shared: the preload path only owns it while IDLE.
    assign w_ram_we    = !reset && ((w_in_access && r_write) || w_preload);
    assign w_ram_re    = !reset && w_in_access && !r_write;
    assign w_ram_addr  = w_in_access ? r_addr  : load_addr[ADDR_BITS-1:0];
    assign w_ram_wdata = w_in_access ? r_wdata : load_data;
    assign w_resp_word = r_write ? r_wdata : w_ram_rdata;

    tron_word_ram #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_WORD (INIT_WORD)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write    <= req_write;
                r_addr     <= req_addr[ADDR_BITS-1:0];
                r_wdata    <= req_wdata;
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            // Keep the last response word visible between pulses.
            if (r_state == RESP) begin
                r_rsp_data <= w_resp_word;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) && !reset;
        busy      = (r_state != IDLE) && !reset;
        rsp_valid = (r_state == RESP) && !reset;
        rsp_write = rsp_valid && r_write;
        rsp_data  = rsp_valid ? w_resp_word : r_rsp_data;
    end

endmodule

// File: tb/tb_tron_mem_responder.sv
// Directed bench for tron_mem_responder (ADDR_BITS=8, WAIT_STATES=1).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tron_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_write;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tron_mem_responder #(
        .ADDR_BITS   (8),
        .WAIT_STATES (1),
        .INIT_WORD   (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_write (rsp_write),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from an IDLE falling edge; returns at the falling edge of
    // the IDLE cycle that follows the response.
    task automatic run_req(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_data);
        int          lat;
        int          nlow;
        logic [15:0] rd;
        logic        rw;
        lat  = 0;
        nlow = 0;
        rd   = 16'h0;
        rw   = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        load_en   = 1'b0;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        for (int c = 1; c <= 10; c++) begin
            if (!req_ready) nlow++;
            if (rsp_valid) begin
                lat = c;
                rd  = rsp_data;
                rw  = rsp_write;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        $display("xact %s wr=%0d addr=%h wdata=%h -> data=%h rsp_write=%0d lat=%0d",
                 tag, wr, addr, wd, rd, rw, lat);
        check_eq({tag, ".latency"},  32'(lat),  32'd3);
        check_eq({tag, ".data"},     32'(rd),   32'(exp_data));
        check_eq({tag, ".rsp_write"}, 32'(rw),  32'(wr));
        check_eq({tag, ".ready_low"}, 32'(nlow), 32'd3);
        check_eq({tag, ".one_pulse"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int         n_acc;
        int         n_rsp;
        logic [7:0] rdy_pat;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        load_en   = 1'b0;
        load_addr = 16'h0;
        load_data = 16'h0;

        repeat (3) @(negedge clk);
        check_eq("rst.req_ready", 32'(req_ready), 32'd0);
        check_eq("rst.busy",      32'(busy),      32'd0);
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rsp_data",  32'(rsp_data),  32'd0);
        check_eq("rst.rsp_write", 32'(rsp_write), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst.ready_after", 32'(req_ready), 32'd1);

        // Preload then fetch
        load_en   = 1'b1;
        load_addr = 16'h0001;
        load_data = 16'h0152;
        @(negedge clk);
        load_en = 1'b0;
        check_eq("preload.busy", 32'(busy), 32'd0);
        run_req("fetch1", 1'b0, 16'h0001, 16'h0000, 16'h0152);

        // Store then immediate load of the same address
        run_req("store2", 1'b1, 16'h0002, 16'h0005, 16'h0005);
        run_req("load2",  1'b0, 16'h0002, 16'h0000, 16'h0005);
        check_eq("hold.rsp_data", 32'(rsp_data), 32'h0005);

        // Address wrap
        run_req("store103", 1'b1, 16'h0103, 16'hff94, 16'hff94);
        run_req("load003",  1'b0, 16'h0003, 16'h0000, 16'hff94);

        // Continuous request with preload strobe held high throughout
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0001;
        load_en   = 1'b1;
        load_addr = 16'h0006;
        load_data = 16'hbeef;
        n_acc   = 0;
        n_rsp   = 0;
        rdy_pat = 8'h00;
        for (int c = 0; c < 8; c++) begin
            rdy_pat[c] = req_ready;
            if (req_ready && req_valid) n_acc++;
            if (rsp_valid) begin
                n_rsp++;
                check_eq("hold.rsp_data_b2b", 32'(rsp_data), 32'h0152);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        load_en   = 1'b0;
        $display("xact backtoback accepts=%0d responses=%0d ready=%b", n_acc, n_rsp, rdy_pat);
        check_eq("b2b.accepts",   32'(n_acc),   32'd2);
        check_eq("b2b.responses", 32'(n_rsp),   32'd2);
        check_eq("b2b.ready_pat", 32'(rdy_pat), 32'h11);
        run_req("load006", 1'b0, 16'h0006, 16'h0000, 16'h0000);

        // Preload collides with a request in the same IDLE cycle
        load_en   = 1'b1;
        load_addr = 16'h0004;
        load_data = 16'h1234;
        run_req("collide", 1'b0, 16'h0004, 16'h0000, 16'h0000);
        run_req("load004", 1'b0, 16'h0004, 16'h0000, 16'h0000);

        // Reset in the middle of a STORE
        load_en   = 1'b1;
        load_addr = 16'h0005;
        load_data = 16'h0033;
        @(negedge clk);
        load_en = 1'b0;
        run_req("fetch1b", 1'b0, 16'h0001, 16'h0000, 16'h0152);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0005;
        req_wdata = 16'h00aa;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("midrst.busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check_eq("midrst.busy",      32'(busy),      32'd0);
        check_eq("midrst.req_ready", 32'(req_ready), 32'd0);
        check_eq("midrst.rsp_data",  32'(rsp_data),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        if (rsp_valid) n_rsp++;
        $display("xact midreset responses=%0d ready_after=%0d", n_rsp, req_ready);
        check_eq("midrst.no_rsp",      32'(n_rsp),     32'd0);
        check_eq("midrst.ready_after", 32'(req_ready), 32'd1);
        run_req("load005", 1'b0, 16'h0005, 16'h0000, 16'h0033);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
